// File: rtl/row_reduction_scheduler_pkg.sv
// Shared definitions for the row reduction scheduler: default widths,
// watchdog limit and the sequencer state encoding.
package row_reduction_scheduler_pkg;

  localparam int unsigned DEF_ELEMENT_WIDTH  = 32;
  localparam int unsigned DEF_NO_OF_UNITS    = 128;
  localparam int unsigned DEF_ROW_WIDTH      = 16;
  localparam int unsigned DEF_CHUNK_WIDTH    = 8;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_TREE = 3'd3,
    ST_WAIT_SUM  = 3'd4,
    ST_EMIT      = 3'd5,
    ST_GAP       = 3'd6
  } rrs_state_t;

  // The organizer accumulates only while start is high; IDLE and GAP clear it.
  function automatic logic row_active(input rrs_state_t s);
    return (s != ST_IDLE) && (s != ST_GAP);
  endfunction

endpackage

// File: rtl/row_reduction_scheduler_timeout.sv
// Watchdog counter shared by the tree-finish and final-sum waits:
// clear has priority, increments saturate, tc_o flags the last allowed wait cycle.
module finish_timeout_counter #(
  parameter int unsigned limit = 1024
) (
  input  logic clk,
  input  logic rst_i,
  input  logic clear_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam int unsigned CNT_W = (limit < 2) ? 1 : $clog2(limit + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(limit - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == LAST);

endmodule

// File: rtl/row_reduction_scheduler.sv
// Sequences the 128-input row organizer through a matrix-vector reduction:
// fetch each chunk of a row, issue it, collect the accumulated row sum, emit it.
module row_reduction_scheduler
  import row_reduction_scheduler_pkg::*;
#(
  parameter int unsigned element_width  = DEF_ELEMENT_WIDTH,
  parameter int unsigned no_of_units    = DEF_NO_OF_UNITS,
  parameter int unsigned row_width      = DEF_ROW_WIDTH,
  parameter int unsigned chunk_width    = DEF_CHUNK_WIDTH,
  parameter int unsigned timeout_cycles = DEF_TIMEOUT_CYCLES
) (
  input  logic                                 clk,
  input  logic                                 main_reset,
  input  logic                                 cmd_valid,
  output logic                                 cmd_ready,
  input  logic [row_width-1:0]                 cmd_rows,
  input  logic [chunk_width-1:0]               cmd_chunks,
  output logic                                 chunk_req,
  output logic [row_width-1:0]                 chunk_row,
  output logic [chunk_width-1:0]               chunk_idx,
  input  logic                                 chunk_valid,
  input  logic [no_of_units*element_width-1:0] chunk_data,
  output logic [no_of_units*element_width-1:0] org_row_input,
  output logic                                 org_start,
  output logic                                 org_outsider4,
  output logic                                 org_reset,
  input  logic                                 org_exe_finish,
  input  logic                                 org_final_finish,
  input  logic [element_width-1:0]             org_adder_output,
  output logic                                 result_valid,
  input  logic                                 result_ready,
  output logic [element_width-1:0]             result_data,
  output logic [row_width-1:0]                 result_row,
  output logic                                 done,
  output logic                                 timeout_err,
  output rrs_state_t                           dbg_state
);

  localparam int unsigned DW = no_of_units * element_width;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready and its payload is held until then.

  rrs_state_t             state_q, state_d;
  logic [row_width-1:0]   rows_q, rows_d, row_q, row_d;
  logic [chunk_width-1:0] chunks_q, chunks_d, chunk_q, chunk_d;
  logic [chunk_width-1:0] fin_cnt_q, fin_cnt_d, fin_cnt_inc;
  logic [DW-1:0]          row_input_q, row_input_d;
  logic [element_width-1:0] result_q, result_d;
  logic                   timeout_err_q, timeout_err_d;
  logic                   done_q, done_d;
  logic                   org_rst_q, org_rst_d;
  logic                   wd_clear, wd_inc, wd_tc, timed_out;
  logic                   fin_counting, more_chunks, last_row;

  finish_timeout_counter #(
    .limit (timeout_cycles)
  ) u_watchdog (
    .clk     (clk),
    .rst_i   (main_reset),
    .clear_i (wd_clear),
    .inc_i   (wd_inc),
    .tc_o    (wd_tc)
  );

  assign more_chunks = ({1'b0, chunk_q} + 1'b1) < {1'b0, chunks_q};
  assign last_row    = ({1'b0, row_q} + 1'b1) >= {1'b0, rows_q};

  // Final-sum pulses may land while the tree is still busy; count them from ISSUE on.
  assign fin_counting = (state_q == ST_ISSUE) || (state_q == ST_WAIT_TREE) ||
                        (state_q == ST_WAIT_SUM);
  assign fin_cnt_inc  = (fin_counting && org_final_finish && (fin_cnt_q != '1)) ?
                        fin_cnt_q + 1'b1 : fin_cnt_q;

  always_comb begin
    state_d       = state_q;
    rows_d        = rows_q;
    chunks_d      = chunks_q;
    row_d         = row_q;
    chunk_d       = chunk_q;
    fin_cnt_d     = fin_cnt_inc;
    row_input_d   = row_input_q;
    result_d      = result_q;
    timeout_err_d = timeout_err_q;
    done_d        = 1'b0;
    org_rst_d     = 1'b0;
    wd_clear      = 1'b1;
    wd_inc        = 1'b0;
    timed_out     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          rows_d        = cmd_rows;
          chunks_d      = (cmd_chunks == '0) ? chunk_width'(1) : cmd_chunks;
          row_d         = '0;
          chunk_d       = '0;
          fin_cnt_d     = '0;
          timeout_err_d = 1'b0;
          if (cmd_rows == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        if (chunk_valid) begin
          row_input_d = chunk_data;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_TREE;
      end
      ST_WAIT_TREE: begin
        wd_clear = 1'b0;
        wd_inc   = 1'b1;
        if (org_exe_finish) begin
          wd_clear = 1'b1;
          if (more_chunks) begin
            chunk_d = chunk_q + 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WAIT_SUM;
          end
        end else if (wd_tc) begin
          timed_out = 1'b1;
        end
      end
      ST_WAIT_SUM: begin
        wd_clear = 1'b0;
        wd_inc   = 1'b1;
        if (fin_cnt_inc >= chunks_q) begin
          result_d = org_adder_output;
          state_d  = ST_EMIT;
        end else if (wd_tc) begin
          timed_out = 1'b1;
        end
      end
      ST_EMIT: begin
        if (result_ready) begin
          if (last_row) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        row_d     = (row_q != '1) ? row_q + 1'b1 : row_q;
        chunk_d   = '0;
        fin_cnt_d = '0;
        state_d   = ST_FETCH;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (timed_out) begin
      timeout_err_d = 1'b1;
      org_rst_d     = 1'b1;
      done_d        = 1'b1;
      wd_clear      = 1'b1;
      state_d       = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (main_reset) begin
      state_q       <= ST_IDLE;
      rows_q        <= '0;
      chunks_q      <= '0;
      row_q         <= '0;
      chunk_q       <= '0;
      fin_cnt_q     <= '0;
      row_input_q   <= '0;
      result_q      <= '0;
      timeout_err_q <= 1'b0;
      done_q        <= 1'b0;
      org_rst_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      rows_q        <= rows_d;
      chunks_q      <= chunks_d;
      row_q         <= row_d;
      chunk_q       <= chunk_d;
      fin_cnt_q     <= fin_cnt_d;
      row_input_q   <= row_input_d;
      result_q      <= result_d;
      timeout_err_q <= timeout_err_d;
      done_q        <= done_d;
      org_rst_q     <= org_rst_d;
    end
  end

  // Outputs are forced to their reset values for as long as reset is held.
  always_comb begin
    cmd_ready     = 1'b0;
    chunk_req     = 1'b0;
    chunk_row     = '0;
    chunk_idx     = '0;
    org_row_input = '0;
    org_start     = 1'b0;
    org_outsider4 = 1'b0;
    org_reset     = 1'b1;
    result_valid  = 1'b0;
    result_data   = '0;
    result_row    = '0;
    done          = 1'b0;
    timeout_err   = 1'b0;
    dbg_state     = ST_IDLE;
    if (!main_reset) begin
      cmd_ready     = (state_q == ST_IDLE);
      chunk_req     = (state_q == ST_FETCH);
      chunk_row     = row_q;
      chunk_idx     = chunk_q;
      org_row_input = row_input_q;
      org_start     = row_active(state_q);
      org_outsider4 = (state_q == ST_ISSUE);
      org_reset     = org_rst_q;
      result_valid  = (state_q == ST_EMIT);
      result_data   = result_q;
      result_row    = row_q;
      done          = done_q;
      timeout_err   = timeout_err_q;
      dbg_state     = state_q;
    end
  end

endmodule

// File: tb/tb_row_reduction_scheduler.sv
// Bench for row_reduction_scheduler: behavioural organizer, chunk source and
// result sink driven on the falling edge, with a row-sum reference model.
module tb_row_reduction_scheduler;

  localparam int EW = 32;
  localparam int NU = 128;
  localparam int RW = 16;
  localparam int CW = 8;
  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              main_reset;
  logic              cmd_valid, cmd_ready;
  logic [RW-1:0]     cmd_rows;
  logic [CW-1:0]     cmd_chunks;
  logic              chunk_req, chunk_valid;
  logic [RW-1:0]     chunk_row;
  logic [CW-1:0]     chunk_idx;
  logic [NU*EW-1:0]  chunk_data, org_row_input;
  logic              org_start, org_outsider4, org_reset;
  logic              org_exe_finish, org_final_finish;
  logic [EW-1:0]     org_adder_output;
  logic              result_valid, result_ready;
  logic [EW-1:0]     result_data;
  logic [RW-1:0]     result_row;
  logic              done, timeout_err;
  logic [2:0]        dbg_state;

  row_reduction_scheduler #(
    .element_width (EW), .no_of_units (NU), .row_width (RW),
    .chunk_width (CW), .timeout_cycles (TO)
  ) dut (
    .clk (clk), .main_reset (main_reset),
    .cmd_valid (cmd_valid), .cmd_ready (cmd_ready),
    .cmd_rows (cmd_rows), .cmd_chunks (cmd_chunks),
    .chunk_req (chunk_req), .chunk_row (chunk_row), .chunk_idx (chunk_idx),
    .chunk_valid (chunk_valid), .chunk_data (chunk_data),
    .org_row_input (org_row_input), .org_start (org_start),
    .org_outsider4 (org_outsider4), .org_reset (org_reset),
    .org_exe_finish (org_exe_finish), .org_final_finish (org_final_finish),
    .org_adder_output (org_adder_output),
    .result_valid (result_valid), .result_ready (result_ready),
    .result_data (result_data), .result_row (result_row),
    .done (done), .timeout_err (timeout_err), .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Exact float encoding of small non-negative integers (< 2^24).
  function automatic logic [31:0] int_to_f32(input int unsigned n);
    int e;
    logic [31:0] m;
    if (n == 0) return 32'h0;
    e = 0;
    for (int i = 0; i < 24; i++) if (n[i]) e = i;
    m = n << (23 - e);
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  // Stimulus table and expectations
  logic [31:0] tab [0:5][0:3][0:3];
  logic [47:0] exp_q[$];
  logic [23:0] exp_req_q[$];
  int          cur_eff = 1;
  bit          bp_mode = 0;
  bit          suppress_exe = 0;
  bit          suppress_fin = 0;

  // Monitor counters
  int cyc = 0, done_cnt = 0, out4_cnt = 0, gap_cnt = 0, rst_cnt = 0;
  int res_cnt = 0, exe_seen = 0, last_out4_cyc = 0;
  logic [31:0] last_result = '0;

  // Organizer model state
  int          exe_due_q[$];
  int          fin_due_q[$];
  int unsigned fin_sum_q[$];
  int unsigned acc = 0;
  int          issues = 0;
  int          fetch_wait = 0;
  bit          valid_drv_prev = 0;
  bit          valid_prev = 0;
  int          bp_left = 0;
  logic [EW-1:0] snap_data;
  logic [RW-1:0] snap_row;

  function automatic logic [NU*EW-1:0] build_chunk(input int r, input int c);
    logic [NU*EW-1:0] d;
    d = '0;
    d[0*EW +: EW]   = tab[r][c][0];
    d[1*EW +: EW]   = tab[r][c][1];
    d[64*EW +: EW]  = tab[r][c][2];
    d[127*EW +: EW] = tab[r][c][3];
    return d;
  endfunction

  initial begin
    int unsigned s;
    int le, lf;
    logic [23:0] e;
    logic [47:0] x;
    chunk_valid = 0; chunk_data = '0; org_exe_finish = 0; org_final_finish = 0;
    org_adder_output = '0; result_ready = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (done) done_cnt++;
      if (org_outsider4) begin out4_cnt++; last_out4_cyc = cyc; end
      if (!main_reset && !org_start && !cmd_ready) gap_cnt++;
      if (!main_reset && org_reset) rst_cnt++;
      org_exe_finish = 0;
      org_final_finish = 0;
      if (org_reset) begin
        exe_due_q.delete(); fin_due_q.delete(); fin_sum_q.delete();
        acc = 0; issues = 0; chunk_valid = 0; result_ready = 0;
        valid_drv_prev = 0; valid_prev = 0;
      end else begin
        // organizer
        if (valid_drv_prev) check_eq("issue_latency", org_outsider4, 1);
        if (!org_start) begin acc = 0; issues = 0; end
        if (org_outsider4) begin
          s = 0;
          for (int w = 0; w < NU; w++) s += org_row_input[w*EW +: EW];
          issues++;
          le = $urandom_range(1, 3);
          lf = (issues >= cur_eff) ? $urandom_range(0, 3) : 0;
          exe_due_q.push_back(cyc + le);
          fin_due_q.push_back(cyc + le + lf);
          fin_sum_q.push_back(s);
        end
        if (exe_due_q.size() > 0 && exe_due_q[0] == cyc) begin
          void'(exe_due_q.pop_front());
          if (!suppress_exe) begin org_exe_finish = 1; exe_seen++; end
        end
        if (fin_due_q.size() > 0 && fin_due_q[0] == cyc) begin
          void'(fin_due_q.pop_front());
          s = fin_sum_q.pop_front();
          if (!suppress_fin) begin
            acc += s;
            org_adder_output = int_to_f32(acc);
            org_final_finish = 1;
          end
        end
        // chunk source
        valid_drv_prev = 0;
        if (chunk_req) begin
          if (fetch_wait > 0) begin
            fetch_wait--;
            chunk_valid = 0;
          end else if (!chunk_valid) begin
            check_eq("req_expected", exp_req_q.size() > 0, 1);
            if (exp_req_q.size() > 0) begin
              e = exp_req_q.pop_front();
              check_eq("req_row", chunk_row, e[23:8]);
              check_eq("req_idx", chunk_idx, e[7:0]);
              chunk_data = build_chunk(int'(e[23:8]), int'(e[7:0]));
              chunk_valid = 1;
              valid_drv_prev = 1;
            end
          end else begin
            chunk_valid = 0;
          end
        end else begin
          chunk_valid = 0;
          fetch_wait = $urandom_range(0, 2);
        end
        // result sink
        if (result_valid) begin
          if (!valid_prev) begin
            bp_left = bp_mode ? 10 : $urandom_range(0, 2);
            snap_data = result_data;
            snap_row = result_row;
          end else begin
            check_eq("hold_data", result_data, snap_data);
            check_eq("hold_row", result_row, snap_row);
          end
          if (bp_left > 0) begin
            bp_left--;
            result_ready = 0;
            check_eq("bp_no_req", chunk_req, 0);
            valid_prev = 1;
          end else begin
            result_ready = 1;
            valid_prev = 0;
            res_cnt++;
            last_result = result_data;
            check_eq("res_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
              x = exp_q.pop_front();
              check_eq("res_row", result_row, x[47:32]);
              check_eq("res_data", result_data, x[31:0]);
            end
          end
        end else begin
          result_ready = 1'($urandom_range(0, 1));
          valid_prev = 0;
        end
      end
    end
  end

  task automatic load_cmd(input int rows, input int chunks, input int mode);
    int eff;
    int unsigned sum;
    eff = (chunks == 0) ? 1 : chunks;
    for (int r = 0; r < rows; r++) begin
      sum = 0;
      for (int c = 0; c < eff; c++) begin
        for (int k = 0; k < 4; k++) begin
          tab[r][c][k] = (mode == 1) ? ((k == 0) ? 32'(c + 1) : 32'h0) : 32'($urandom_range(0, 255));
          sum += tab[r][c][k];
        end
        exp_req_q.push_back({16'(r), 8'(c)});
      end
      exp_q.push_back({16'(r), int_to_f32(sum)});
    end
    cur_eff = eff;
  endtask

  task automatic send_cmd(input int rows, input int chunks);
    check_eq("cmd_ready_pre", cmd_ready, 1);
    cmd_rows = 16'(rows);
    cmd_chunks = 8'(chunks);
    cmd_valid = 1;
    @(posedge clk);
    #1;
    cmd_valid = 0;
    tick();
  endtask

  task automatic run_cmd(input int rows, input int chunks, input int mode, input bit bp);
    int eff, d0, o0, g0, r0, q0, waited;
    bit got_done;
    eff = (chunks == 0) ? 1 : chunks;
    load_cmd(rows, chunks, mode);
    bp_mode = bp;
    d0 = done_cnt; o0 = out4_cnt; g0 = gap_cnt; r0 = rst_cnt; q0 = res_cnt;
    send_cmd(rows, chunks);
    check_eq("first_req", chunk_req, rows != 0);
    if (rows == 0) check_eq("zero_rows_done", done, 1);
    got_done = done;
    waited = 0;
    while (!got_done && waited < 3000) begin
      tick();
      waited++;
      got_done = done;
    end
    check_eq("done_seen", got_done, 1);
    check_eq("idle_at_done", cmd_ready, 1);
    check_eq("no_timeout_err", timeout_err, 0);
    check_eq("done_count", done_cnt - d0, 1);
    check_eq("outsider4_count", out4_cnt - o0, rows * eff);
    check_eq("gap_cycles", gap_cnt - g0, (rows > 0) ? rows - 1 : 0);
    check_eq("result_count", res_cnt - q0, rows);
    check_eq("results_left", exp_q.size(), 0);
    check_eq("requests_left", exp_req_q.size(), 0);
    check_eq("no_org_reset", rst_cnt - r0, 0);
    tick();
    check_eq("done_pulse_width", done, 0);
    exp_q.delete();
    exp_req_q.delete();
    bp_mode = 0;
  endtask

  initial begin
    int d0, r0, q0, e0, t1, waited;
    bit got_done;
    main_reset = 1; cmd_valid = 0; cmd_rows = '0; cmd_chunks = '0;
    repeat (3) tick();
    check_eq("rst_org_reset", org_reset, 1);
    check_eq("rst_cmd_ready", cmd_ready, 0);
    check_eq("rst_chunk_req", chunk_req, 0);
    check_eq("rst_org_start", org_start, 0);
    check_eq("rst_result_valid", result_valid, 0);
    check_eq("rst_done", done, 0);
    main_reset = 0;
    tick();
    check_eq("post_rst_cmd_ready", cmd_ready, 1);
    check_eq("post_rst_org_reset", org_reset, 0);

    // basic: two rows of 1.0
    run_cmd(2, 1, 1, 0);
    check_eq("basic_value", last_result, 32'h3F800000);
    // accumulation: 1+2+3
    run_cmd(1, 3, 1, 0);
    check_eq("accum_value", last_result, 32'h40C00000);
    // backpressure
    run_cmd(2, 2, 0, 1);
    // zero-size commands
    run_cmd(0, 3, 0, 0);
    run_cmd(2, 0, 1, 0);
    // randomized commands
    for (int i = 0; i < 8; i++) run_cmd($urandom_range(1, 5), $urandom_range(0, 4), 0, 0);

    // tree-finish timeout
    suppress_exe = 1;
    load_cmd(1, 1, 0);
    exp_q.delete();
    d0 = done_cnt; r0 = rst_cnt; q0 = res_cnt;
    send_cmd(1, 1);
    got_done = done;
    waited = 0;
    while (!got_done && waited < 200) begin tick(); waited++; got_done = done; end
    t1 = cyc;
    check_eq("to_done_seen", got_done, 1);
    check_eq("to_err", timeout_err, 1);
    check_eq("to_cmd_ready", cmd_ready, 1);
    check_eq("to_latency", (t1 - last_out4_cyc >= TO) && (t1 - last_out4_cyc <= TO + 2), 1);
    repeat (3) tick();
    check_eq("to_reset_pulses", rst_cnt - r0, 1);
    check_eq("to_done_count", done_cnt - d0, 1);
    check_eq("to_no_result", res_cnt - q0, 0);
    check_eq("to_err_sticky", timeout_err, 1);
    suppress_exe = 0;
    exp_req_q.delete();
    run_cmd(3, 2, 0, 0);

    // reset while waiting for the final sum
    suppress_fin = 1;
    load_cmd(1, 1, 0);
    exp_q.delete();
    d0 = done_cnt; q0 = res_cnt; e0 = exe_seen;
    send_cmd(1, 1);
    waited = 0;
    while (exe_seen == e0 && waited < 50) begin tick(); waited++; end
    check_eq("mid_exe_seen", exe_seen - e0, 1);
    repeat (2) tick();
    check_eq("mid_org_start", org_start, 1);
    check_eq("mid_no_result", result_valid, 0);
    main_reset = 1;
    tick();
    check_eq("mid_rst_org_reset", org_reset, 1);
    check_eq("mid_rst_cmd_ready", cmd_ready, 0);
    check_eq("mid_rst_org_start", org_start, 0);
    check_eq("mid_rst_outsider4", org_outsider4, 0);
    check_eq("mid_rst_result_data", result_data, 0);
    check_eq("mid_rst_done", done, 0);
    tick();
    main_reset = 0;
    suppress_fin = 0;
    tick();
    check_eq("mid_post_cmd_ready", cmd_ready, 1);
    check_eq("mid_no_done", done_cnt - d0, 0);
    check_eq("mid_no_result_out", res_cnt - q0, 0);
    exp_q.delete();
    exp_req_q.delete();
    run_cmd(2, 3, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_time_limit got=expired exp=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
